// File: rtl/esdi_field_framer.sv
// ESDI field framer: hunts for the sync mark, then frames one header or data field per burst.
// Headers are checked with CRC-16/CCITT. Data bytes go out through a single register stage, and the ECC bytes are captured.
module esdi_field_framer #(
    parameter logic [7:0] SYNC_BYTE    = 8'h01,
    parameter int         SECTOR_BYTES = 512,
    parameter int         ECC_BYTES    = 4
) (
    input  logic        parallel_aclk,
    input  logic        parallel_aresetn,
    input  logic        field_is_header,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        hdr_valid,
    output logic [31:0] hdr_data,
    output logic        hdr_crc_ok,
    output logic [63:0] ecc_data,
    output logic        done_valid,
    output logic [3:0]  done_status
);

    localparam int CW = $clog2(SECTOR_BYTES + 1);

    typedef enum logic [2:0] {
        S_HUNT, S_HDR, S_HCRC, S_DATA, S_ECC, S_TAIL, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   crc_q, crc_d;
    logic [7:0]    crc_hi_q, crc_hi_d;
    logic [31:0]   hdr_q, hdr_d;
    logic [63:0]   ecc_q, ecc_d;
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          hdr_valid_q, hdr_valid_d;
    logic          crc_ok_q, crc_ok_d;
    logic          done_valid_q, done_valid_d;
    logic [3:0]    done_status_q, done_status_d;
    logic          err_long_q, err_long_d;
    logic          err_short_q, err_short_d;
    logic          err_nosync_q, err_nosync_d;
    logic          is_hdr_q, is_hdr_d;

    logic          accept;
    logic          complete;
    logic          short_n;
    logic          nosync_n;

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    assign s_tready = (state_q == S_DATA) ? (!m_valid_q || m_tready) : 1'b1;
    assign accept   = s_tvalid && s_tready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        crc_hi_d      = crc_hi_q;
        hdr_d         = hdr_q;
        ecc_d         = ecc_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        hdr_valid_d   = 1'b0;
        crc_ok_d      = crc_ok_q;
        done_valid_d  = 1'b0;
        done_status_d = done_status_q;
        err_long_d    = err_long_q;
        err_short_d   = err_short_q;
        err_nosync_d  = err_nosync_q;
        is_hdr_d      = is_hdr_q;
        complete      = 1'b0;
        short_n       = 1'b0;
        nosync_n      = 1'b0;

        if (m_valid_q && m_tready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_HUNT: begin
                    if (s_tdata == 8'h00) begin
                        state_d = S_HUNT;
                    end else if (s_tdata == SYNC_BYTE) begin
                        state_d  = field_is_header ? S_HDR : S_DATA;
                        cnt_d    = '0;
                        crc_d    = 16'hFFFF;
                        ecc_d    = '0;
                        is_hdr_d = field_is_header;
                    end else begin
                        state_d      = S_DRAIN;
                        err_nosync_d = 1'b1;
                    end
                end
                S_HDR: begin
                    hdr_d = {hdr_q[23:0], s_tdata};
                    crc_d = crc16_upd(crc_q, s_tdata);
                    if (cnt_q == CW'(3)) begin
                        state_d = S_HCRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HCRC: begin
                    if (cnt_q == '0) begin
                        crc_hi_d = s_tdata;
                        cnt_d    = cnt_q + 1'b1;
                    end else begin
                        hdr_valid_d = 1'b1;
                        crc_ok_d    = (crc_q == {crc_hi_q, s_tdata});
                        state_d     = S_TAIL;
                        complete    = 1'b1;
                    end
                end
                S_DATA: begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_tdata;
                    m_last_d  = (cnt_q == CW'(SECTOR_BYTES - 1)) || s_tlast;
                    if (cnt_q == CW'(SECTOR_BYTES - 1)) begin
                        state_d = S_ECC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ECC: begin
                    ecc_d = ecc_q | ({s_tdata, 56'h0} >> (8 * cnt_q[2:0]));
                    if (cnt_q == CW'(ECC_BYTES - 1)) begin
                        state_d  = S_TAIL;
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_TAIL: begin
                    complete = 1'b1;
                    if (!s_tlast) begin
                        err_long_d = 1'b1;
                    end
                end
                S_DRAIN: begin
                    complete = 1'b1;
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase

            // End of burst closes the packet no matter where the field stands
            if (s_tlast) begin
                short_n       = err_short_d | !complete;
                nosync_n      = err_nosync_d | ((state_q == S_HUNT) && (s_tdata != SYNC_BYTE));
                done_valid_d  = 1'b1;
                done_status_d = {err_long_d, short_n, nosync_n, is_hdr_d};
                state_d       = S_HUNT;
                cnt_d         = '0;
                err_long_d    = 1'b0;
                err_short_d   = 1'b0;
                err_nosync_d  = 1'b0;
                is_hdr_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge parallel_aclk) begin
        if (!parallel_aresetn) begin
            state_q       <= S_HUNT;
            cnt_q         <= '0;
            crc_q         <= 16'hFFFF;
            crc_hi_q      <= '0;
            hdr_q         <= '0;
            ecc_q         <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            hdr_valid_q   <= 1'b0;
            crc_ok_q      <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= '0;
            err_long_q    <= 1'b0;
            err_short_q   <= 1'b0;
            err_nosync_q  <= 1'b0;
            is_hdr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            crc_hi_q      <= crc_hi_d;
            hdr_q         <= hdr_d;
            ecc_q         <= ecc_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            hdr_valid_q   <= hdr_valid_d;
            crc_ok_q      <= crc_ok_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
            err_long_q    <= err_long_d;
            err_short_q   <= err_short_d;
            err_nosync_q  <= err_nosync_d;
            is_hdr_q      <= is_hdr_d;
        end
    end

    assign m_tvalid    = m_valid_q;
    assign m_tdata     = m_data_q;
    assign m_tlast     = m_last_q;
    assign hdr_valid   = hdr_valid_q;
    assign hdr_data    = hdr_q;
    assign hdr_crc_ok  = crc_ok_q;
    assign ecc_data    = ecc_q;
    assign done_valid  = done_valid_q;
    assign done_status = done_status_q;

endmodule
